// File: rtl/pixel_serializer_3_if.sv
// Purpose: bundles the two valid/ready streams around pixel_serializer_3.
//   The upstream side carries one TAPS-pixel word per handshake
//   (din[k*DW +: DW] = tap k, tap TAPS-1 is the oldest) plus an end-of-line
//   flag; the downstream side carries one pixel per handshake with
//   first/last markers.
// Signals:
//   in_valid, in_ready, din[TAPS*DW], in_last   word stream into the block
//   dout[DW], out_valid, out_ready              pixel stream out of the block
//   out_first, out_last                         pixel position markers
// Modports:
//   slave  - the serializer itself
//   master - whoever drives words in and consumes pixels (upstream/downstream)
interface pixel_serializer_3_if #(
  parameter int DW   = 8,
  parameter int TAPS = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [TAPS*DW-1:0]   din;
  logic                 in_last;
  logic [DW-1:0]        dout;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_first;
  logic                 out_last;

  modport slave (
    input  in_valid, din, in_last, out_ready,
    output in_ready, dout, out_valid, out_first, out_last
  );

  modport master (
    output in_valid, din, in_last, out_ready,
    input  in_ready, dout, out_valid, out_first, out_last
  );
endinterface

// File: rtl/pixel_serializer_3.sv
// Purpose: inverse of the 3-tap pixel window shifter. Accepts one word of
//   TAPS pixels {tap TAPS-1 (oldest) .. tap 0 (newest)} per handshake and
//   replays it as a one-pixel-per-cycle stream, oldest pixel first. The
//   final pixel of a word can be emitted in the same cycle the next word is
//   accepted, so a continuously fed block sustains one pixel per cycle.
// Ports:
//   clk  - single clock, all state on the rising edge
//   rst  - synchronous active-high reset; discards any partial word
//   bus  - pixel_serializer_3_if.slave: word input stream, pixel output
//          stream and the out_first/out_last markers
// Parameters:
//   DW   - pixel width in bits
//   TAPS - pixels per input word (2..8)
module pixel_serializer_3 #(
  parameter int DW   = 8,
  parameter int TAPS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  pixel_serializer_3_if.slave   bus
);

  localparam int IW = $clog2(TAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_next;
  logic [TAPS*DW-1:0]  hold;
  logic                lastf;

  logic                out_valid;
  logic                in_ready;
  logic                at_last;
  logic                acc;
  logic                emit;
  logic [IW-1:0]       tap_sel;
  logic [DW-1:0]       dout_mux;

  // Handshake decode. A new word may only be taken when the holding
  // register is empty or its final pixel is leaving this very cycle, which
  // is what gives back-to-back words without a bubble (out_ready feeds
  // in_ready combinationally on purpose).
  always_comb begin
    out_valid = (state == BUSY);
    at_last   = (idx == LAST_IDX);
    in_ready  = !rst && (!out_valid || (at_last && bus.out_ready));
    acc       = bus.in_valid && in_ready;
    emit      = out_valid && bus.out_ready;
  end

  // Next-state logic: a load always restarts at the oldest tap; otherwise
  // each emitted pixel steps idx until the last tap drains the word.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    if (acc) begin
      state_next = BUSY;
      idx_next   = '0;
    end else if (emit) begin
      if (!at_last) begin
        idx_next = idx + 1'b1;
      end else begin
        state_next = EMPTY;
        idx_next   = '0;
      end
    end
  end

  // State register; reset also clears the held word so dout reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      idx   <= '0;
      hold  <= '0;
      lastf <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (acc) begin
        hold  <= bus.din;
        lastf <= bus.in_last;
      end
    end
  end

  // Output pixel is a plain mux over the held word: idx 0 selects the
  // oldest tap (TAPS-1), so the slice index runs backwards from idx.
  always_comb begin
    tap_sel  = LAST_IDX - idx;
    dout_mux = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (tap_sel == IW'(k)) begin
        dout_mux = hold[k*DW +: DW];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.dout      = dout_mux;
  assign bus.out_first = out_valid && (idx == '0);
  assign bus.out_last  = out_valid && lastf && at_last;

endmodule
